// File: rtl/instr_encoder_pkg.sv
// Shared types, opcode constants and the word-building helper for the
// instruction encoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    K_DP  = 3'd0,
    K_MEM = 3'd1,
    K_BR  = 3'd2,
    K_SWI = 3'd3,
    K_MUL = 3'd4,
    K_MRS = 3'd5,
    K_MSR = 3'd6,
    K_RSV = 3'd7
  } kind_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [31:0] ERR_INSTR_DEFAULT = 32'hE1A00000;

  typedef struct packed {
    kind_t       kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        imm;
    logic        link;
    logic        load;
    logic        spsr;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [31:0] imm32;
  } req_t;

  // Returns {err, word}. imm12 is only consulted for DP with the I bit set;
  // the caller supplies it once the rotation search has found it.
  function automatic logic [32:0] encode(input req_t r, input logic [11:0] imm12,
                                         input logic [31:0] err_instr);
    logic        err;
    logic [31:0] w;
    logic [31:0] mag;
    err = 1'b0;
    w   = '0;
    mag = r.imm32[31] ? (~r.imm32 + 32'd1) : r.imm32;
    case (r.kind)
      K_DP:  w = {r.cond, 2'b00, r.imm, r.cmd, r.s, r.rn, r.rd,
                  r.imm ? imm12 : {8'h00, r.rm}};
      K_MEM: begin
        w   = {r.cond, 2'b01, 1'b0, 1'b1, ~r.imm32[31], 1'b0, 1'b0, r.load,
               r.rn, r.rd, mag[11:0]};
        err = (mag > 32'd4095);
      end
      K_BR: begin
        w   = {r.cond, 3'b101, r.link, r.imm32[25:2]};
        // Signed 26-bit range: the top seven bits must be pure sign extension.
        err = (r.imm32[1:0] != 2'b00) || !((&r.imm32[31:25]) || !(|r.imm32[31:25]));
      end
      K_SWI: begin
        w   = {r.cond, 4'b1111, r.imm32[23:0]};
        err = |r.imm32[31:24];
      end
      K_MUL: w = {r.cond, 7'b0000000, r.s, r.rd, 4'b0000, r.rs, 4'b1001, r.rm};
      K_MRS: w = {r.cond, 5'b00010, r.spsr, 2'b00, 4'hF, r.rd, 12'h000};
      K_MSR: w = {r.cond, 5'b00010, r.spsr, 2'b10, 4'hF, 4'hF, 8'h00, r.rm};
      default: err = 1'b1;
    endcase
    if (err) w = err_instr;
    return {err, w};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and result channels of the instruction encoder.
// Both channels use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; a source holds valid and its payload until then.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [3:0]  req_cond;
  logic [3:0]  req_cmd;
  logic        req_s;
  logic        req_imm;
  logic        req_link;
  logic        req_load;
  logic        req_spsr;
  logic [3:0]  req_rd;
  logic [3:0]  req_rn;
  logic [3:0]  req_rm;
  logic [3:0]  req_rs;
  logic [31:0] req_imm32;
  logic        enc_valid;
  logic        enc_ready;
  logic [31:0] enc_instr;
  logic        enc_err;

  modport slave (
    input  req_valid, req_kind, req_cond, req_cmd, req_s, req_imm, req_link,
           req_load, req_spsr, req_rd, req_rn, req_rm, req_rs, req_imm32, enc_ready,
    output req_ready, enc_valid, enc_instr, enc_err
  );

  modport master (
    output req_valid, req_kind, req_cond, req_cmd, req_s, req_imm, req_link,
           req_load, req_spsr, req_rd, req_rn, req_rm, req_rs, req_imm32, enc_ready,
    input  req_ready, enc_valid, enc_instr, enc_err
  );
endinterface

// File: rtl/imm_rot_check.sv
// Tests whether imm32 rotated left by 2*rot fits in eight bits, which is the
// same as imm32 == imm8 rotated right by 2*rot.
module imm_rot_check (
  input  logic [31:0] imm32,
  input  logic [3:0]  rot,
  output logic        match,
  output logic [7:0]  imm8
);
  logic [63:0] wide;
  logic [31:0] rotl;

  assign wide  = {imm32, imm32} << {rot, 1'b0};
  assign rotl  = wide[63:32];
  assign match = (rotl[31:8] == 24'h000000);
  assign imm8  = rotl[7:0];
endmodule

// File: rtl/instr_encoder.sv
// Encodes one request per transaction into a 32-bit ARM instruction word,
// searching rotations serially for DP immediates.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] ERR_INSTR = ERR_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus,
  output state_t          state_dbg
);
  state_t      state_q, state_n;
  logic [3:0]  rot_q, rot_n;
  req_t        req_q, req_live;
  logic [31:0] instr_q, out_word;
  logic        err_q, out_err;
  logic        load_req, load_out, clr_err;
  logic        rot_match;
  logic [7:0]  rot_imm8;

  assign req_live = '{
    kind:  kind_t'(bus.req_kind),
    cond:  bus.req_cond,
    cmd:   bus.req_cmd,
    s:     bus.req_s,
    imm:   bus.req_imm,
    link:  bus.req_link,
    load:  bus.req_load,
    spsr:  bus.req_spsr,
    rd:    bus.req_rd,
    rn:    bus.req_rn,
    rm:    bus.req_rm,
    rs:    bus.req_rs,
    imm32: bus.req_imm32
  };

  imm_rot_check u_rot (
    .imm32 (req_q.imm32),
    .rot   (rot_q),
    .match (rot_match),
    .imm8  (rot_imm8)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rot_q   <= 4'd0;
      req_q   <= '0;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rot_q   <= rot_n;
      if (load_req) req_q <= req_live;
      if (load_out) begin
        instr_q <= out_word;
        err_q   <= out_err;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    rot_n    = rot_q;
    load_req = 1'b0;
    load_out = 1'b0;
    clr_err  = 1'b0;
    out_word = 32'h0;
    out_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          load_req = 1'b1;
          if (req_live.kind == K_DP && req_live.imm) begin
            state_n = S_ROT;
            rot_n   = 4'd0;
          end else begin
            // Non-search kinds are encoded straight from the live inputs so
            // the result is visible right after the accepting edge.
            state_n  = S_OUT;
            load_out = 1'b1;
            {out_err, out_word} = encode(req_live, 12'h000, ERR_INSTR);
          end
        end
      end
      S_ROT: begin
        if (rot_match) begin
          state_n  = S_OUT;
          load_out = 1'b1;
          {out_err, out_word} = encode(req_q, {rot_q, rot_imm8}, ERR_INSTR);
        end else if (rot_q == 4'hF) begin
          state_n  = S_OUT;
          load_out = 1'b1;
          out_err  = 1'b1;
          out_word = ERR_INSTR;
        end else begin
          rot_n = rot_q + 4'd1;
        end
      end
      S_OUT: begin
        if (bus.enc_ready) begin
          state_n = S_IDLE;
          clr_err = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.enc_valid = (state_q == S_OUT);
  assign bus.enc_instr = instr_q;
  assign bus.enc_err   = err_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus random requests checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] ERR_W = 32'hE1A00000;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t state_dbg;
  int unsigned cyc = 0;

  instr_encoder_if bus();

  instr_encoder #(.ERR_INSTR(ERR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [7:0]  lat;
    logic [31:0] acc;
    logic [3:0]  hold;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: field placement by shifts and integer arithmetic.
  function automatic exp_t model(input req_t r);
    exp_t        e;
    longint      v, a, w;
    logic [31:0] rv;
    int          found;
    logic        bad;
    e = '0; bad = 1'b0; w = 0; e.lat = 8'd1;
    v = longint'($signed(r.imm32));
    case (r.kind)
      K_DP: begin
        w = (longint'(r.cond) << 28) | (longint'(r.imm) << 25) | (longint'(r.cmd) << 21) |
            (longint'(r.s) << 20) | (longint'(r.rn) << 16) | (longint'(r.rd) << 12);
        if (!r.imm) w = w | longint'(r.rm);
        else begin
          found = -1;
          for (int k = 0; k < 16; k++) begin
            rv = (k == 0) ? r.imm32 : ((r.imm32 << (2 * k)) | (r.imm32 >> (32 - 2 * k)));
            if (found < 0 && rv < 32'd256) begin
              found = k;
              w = w | (longint'(k) << 8) | longint'(rv);
            end
          end
          if (found < 0) begin bad = 1'b1; e.lat = 8'd17; end
          else e.lat = 8'(found + 2);
        end
      end
      K_MEM: begin
        a = (v < 0) ? -v : v;
        bad = (a > 4095);
        w = (longint'(r.cond) << 28) | (64'd1 << 26) | (64'd1 << 24) |
            ((v >= 0) ? (64'd1 << 23) : 64'd0) | (longint'(r.load) << 20) |
            (longint'(r.rn) << 16) | (longint'(r.rd) << 12) | (a & 64'hFFF);
      end
      K_BR: begin
        bad = (v % 4 != 0) || (v < -(64'sd1 <<< 25)) || (v > (64'sd1 <<< 25) - 1);
        w = (longint'(r.cond) << 28) | (64'd5 << 25) | (longint'(r.link) << 24) |
            ((v / 4) & 64'hFFFFFF);
      end
      K_SWI: begin
        bad = (r.imm32 > 32'h00FFFFFF);
        w = (longint'(r.cond) << 28) | (64'hF << 24) | (longint'(r.imm32) & 64'hFFFFFF);
      end
      K_MUL: w = (longint'(r.cond) << 28) | (longint'(r.s) << 20) | (longint'(r.rd) << 16) |
                 (longint'(r.rs) << 8) | (64'd9 << 4) | longint'(r.rm);
      K_MRS: w = (longint'(r.cond) << 28) | (64'd1 << 24) | (longint'(r.spsr) << 22) |
                 (64'hF << 16) | (longint'(r.rd) << 12);
      K_MSR: w = (longint'(r.cond) << 28) | (64'd1 << 24) | (longint'(r.spsr) << 22) |
                 (64'd1 << 21) | (64'hF << 16) | (64'hF << 12) | longint'(r.rm);
      default: bad = 1'b1;
    endcase
    e.err   = bad;
    e.instr = bad ? ERR_W : 32'(w);
    return e;
  endfunction

  task automatic drive_req(input req_t r);
    bus.req_kind  = r.kind;
    bus.req_cond  = r.cond;
    bus.req_cmd   = r.cmd;
    bus.req_s     = r.s;
    bus.req_imm   = r.imm;
    bus.req_link  = r.link;
    bus.req_load  = r.load;
    bus.req_spsr  = r.spsr;
    bus.req_rd    = r.rd;
    bus.req_rn    = r.rn;
    bus.req_rm    = r.rm;
    bus.req_rs    = r.rs;
    bus.req_imm32 = r.imm32;
  endtask

  // Called at a negedge; presents one request and records what must come back.
  task automatic send(input req_t r, input int hold, input bit fixed,
                      input logic [31:0] fi, input logic fe, input int fl);
    exp_t e;
    int t = 0;
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    drive_req(r);
    bus.req_valid = 1'b1;
    e = model(r);
    if (fixed) begin e.instr = fi; e.err = fe; e.lat = 8'(fl); end
    e.acc  = cyc;
    e.hold = 4'(hold);
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_imm32 = $urandom;
  endtask

  function automatic req_t mk(input kind_t k, input logic [3:0] cmd, input logic imm,
                              input logic [3:0] rd, input logic [3:0] rn,
                              input logic [31:0] imm32);
    req_t r;
    r = '0;
    r.kind = k; r.cond = 4'hE; r.cmd = cmd; r.imm = imm;
    r.rd = rd; r.rn = rn; r.imm32 = imm32;
    return r;
  endfunction

  // Monitor: pops on the first cycle of each result and drives enc_ready.
  exp_t        cur;
  logic        prev_valid = 1'b0;
  int          hold_left = 0;
  logic [31:0] last_instr;
  logic        last_err;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      bus.enc_ready = 1'b0;
    end else if (bus.enc_valid) begin
      check("busy_req_ready", {31'b0, bus.req_ready}, 32'd0);
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h with nothing expected", bus.enc_instr);
          hold_left = 0;
        end else begin
          cur = exp_q.pop_front();
          check("enc_instr", bus.enc_instr, cur.instr);
          check("enc_err", {31'b0, bus.enc_err}, {31'b0, cur.err});
          check("latency", cyc - cur.acc, {24'b0, cur.lat});
          hold_left = int'(cur.hold);
        end
      end else begin
        check("stable_instr", bus.enc_instr, last_instr);
        check("stable_err", {31'b0, bus.enc_err}, {31'b0, last_err});
      end
      last_instr = bus.enc_instr;
      last_err   = bus.enc_err;
      prev_valid = 1'b1;
      if (hold_left > 0) begin bus.enc_ready = 1'b0; hold_left--; end
      else bus.enc_ready = 1'b1;
    end else begin
      prev_valid = 1'b0;
      check("idle_err", {31'b0, bus.enc_err}, 32'd0);
      bus.enc_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    req_t r;
    int t;
    bus.req_valid = 1'b0;
    drive_req('0);
    bus.enc_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_enc_valid", {31'b0, bus.enc_valid}, 32'd0);
    check("rst_enc_instr", bus.enc_instr, 32'h0);
    check("rst_enc_err", {31'b0, bus.enc_err}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, {30'b0, S_IDLE});
    reset = 1'b0;
    @(negedge clk);

    send(mk(K_DP, CMD_ADD, 1'b1, 4'd1, 4'd2, 32'h000000FF), 0, 1, 32'hE28210FF, 1'b0, 2);
    send(mk(K_DP, CMD_MOV, 1'b1, 4'd0, 4'd0, 32'hFF000000), 1, 1, 32'hE3A004FF, 1'b0, 6);
    send(mk(K_DP, CMD_MOV, 1'b1, 4'd0, 4'd0, 32'h00000101), 0, 1, ERR_W, 1'b1, 17);
    r = mk(K_MEM, 4'd0, 1'b0, 4'd3, 4'd4, -32'sd8); r.load = 1'b1;
    send(r, 0, 1, 32'hE5143008, 1'b0, 1);
    r = mk(K_BR, 4'd0, 1'b0, 4'd0, 4'd0, 32'h100); r.link = 1'b1;
    send(r, 2, 1, 32'hEB000040, 1'b0, 1);
    send(mk(K_BR, 4'd0, 1'b0, 4'd0, 4'd0, 32'h102), 0, 1, ERR_W, 1'b1, 1);
    r = mk(K_MUL, 4'd0, 1'b0, 4'd1, 4'd0, 32'h0); r.rm = 4'd2; r.rs = 4'd3;
    send(r, 5, 1, 32'hE0010392, 1'b0, 1);
    send(mk(K_RSV, 4'd0, 1'b0, 4'd1, 4'd1, 32'h0), 0, 1, ERR_W, 1'b1, 1);
    send(mk(K_MEM, 4'd0, 1'b0, 4'd1, 4'd1, 32'd4096), 0, 0, '0, 1'b0, 0);
    send(mk(K_MEM, 4'd0, 1'b0, 4'd1, 4'd1, -32'sd4095), 0, 0, '0, 1'b0, 0);
    send(mk(K_SWI, 4'd0, 1'b0, 4'd0, 4'd0, 32'h01000000), 0, 0, '0, 1'b0, 0);
    send(mk(K_BR, 4'd0, 1'b0, 4'd0, 4'd0, 32'h01FFFFFC), 0, 0, '0, 1'b0, 0);
    send(mk(K_BR, 4'd0, 1'b0, 4'd0, 4'd0, 32'h02000000), 0, 0, '0, 1'b0, 0);
    send(mk(K_BR, 4'd0, 1'b0, 4'd0, 4'd0, 32'hFE000000), 0, 0, '0, 1'b0, 0);
    send(mk(K_DP, CMD_SUB, 1'b1, 4'd5, 4'd6, 32'hC000003F), 0, 0, '0, 1'b0, 0);

    // Reset in the middle of an unencodable search: the request must vanish.
    t = 0;
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    drive_req(mk(K_DP, CMD_MOV, 1'b1, 4'd0, 4'd0, 32'h00000101));
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rot_state", {30'b0, state_dbg}, {30'b0, S_ROT});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("mid_rst_enc_valid", {31'b0, bus.enc_valid}, 32'd0);
    repeat (25) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] b, x;
      int sh;
      r = '0;
      r.kind = kind_t'($urandom_range(0, 7));
      r.cond = 4'($urandom); r.cmd = 4'($urandom);
      r.s = 1'($urandom); r.imm = 1'($urandom); r.link = 1'($urandom);
      r.load = 1'($urandom); r.spsr = 1'($urandom);
      r.rd = 4'($urandom); r.rn = 4'($urandom); r.rm = 4'($urandom); r.rs = 4'($urandom);
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: begin
          b = 32'($urandom_range(0, 255));
          sh = 2 * $urandom_range(0, 15);
          x = (sh == 0) ? b : ((b << sh) | (b >> (32 - sh)));
        end
        2: x = 32'($urandom_range(0, 10000)) - 32'd5000;
        default: x = (32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000) & ~32'($urandom_range(0, 1) * 3);
      endcase
      r.imm32 = x;
      send(r, $urandom_range(0, 2), 0, '0, 1'b0, 0);
    end

    t = 0;
    while ((exp_q.size() != 0 || bus.enc_valid) && t < 2000) begin @(negedge clk); t++; end
    check("drain", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ERR_INSTR, 32'hE1A00000, word emitted when a request is unencodable.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-005 req_kind  input  3  0=DP, 1=MEM, 2=BR, 3=SWI, 4=MUL, 5=MRS, 6=MSR (reg); 7 reserved.
REQ-006 req_cond, req_cmd  input  4 each  condition field; DP opcode.
REQ-007 req_s, req_imm, req_link, req_load, req_spsr  input  1 each  S bit; immediate operand; BL; LDR vs STR; SPSR vs CPSR.
REQ-008 req_rd, req_rn, req_rm, req_rs  input  4 each  register fields.
REQ-009 req_imm32  input  32  immediate, signed offset, or byte branch offset.
REQ-010 enc_valid / enc_ready  output / input  1 / 1  result handshake.
REQ-011 enc_instr  output  32  encoded word.
REQ-012 enc_err  output  1  high with enc_valid when the request was unencodable.

Function
REQ-013 FSM states SHALL be IDLE, ROT, OUT; req_ready SHALL equal (state==IDLE); enc_valid SHALL equal (state==OUT).
REQ-014 On accept (req_valid&&req_ready), all req_* SHALL be registered; DP with req_imm=1 SHALL go to ROT with rot=0, everything else to OUT.
REQ-015 ROT SHALL test one rotation per cycle: match when (imm32 ROL 2*rot)[31:8]==0; match -> OUT with imm12={rot,imm8}; no match at rot=15 -> OUT with error.
REQ-016 Latency: non-search kinds enc_valid 1 cycle after the accepting edge; DP-immediate matching at rot k: k+2 cycles; unencodable: 17 cycles.
REQ-017 DP: {cond,2'b00,I,cmd,S,Rn,Rd,src2}; src2 = imm12 if I, else {8'h00,Rm}.
REQ-018 MEM: {cond,2'b01,1'b0,P=1,U,B=0,W=0,L,Rn,Rd,|imm32|[11:0]}; U=~imm32[31]; |imm32|>4095 SHALL flag error.
REQ-019 BR: {cond,3'b101,link,imm32[25:2]}; imm32[1:0]!=0 or imm32 outside signed 26-bit range SHALL flag error.
REQ-020 SWI: {cond,4'b1111,imm32[23:0]}; imm32[31:24]!=0 SHALL flag error.
REQ-021 MUL: {cond,7'b0,S,Rd,4'b0000,Rs,4'b1001,Rm}.
REQ-022 MRS: {cond,5'b00010,spsr,2'b00,4'hF,Rd,12'h000}; MSR: {cond,5'b00010,spsr,2'b10,4'hF,4'hF,8'h00,Rm}.
REQ-023 Kind 7 SHALL flag error.
REQ-024 Any error SHALL set enc_instr=ERR_INSTR and enc_err=1; otherwise enc_err=0.
REQ-025 In OUT, enc_instr/enc_err SHALL be held stable while enc_ready=0; enc_valid&&enc_ready SHALL return to IDLE; no new request is accepted in the same cycle (no bypass).
REQ-026 In IDLE, enc_instr SHALL hold its last value; enc_err SHALL be 0.

Reset
REQ-027 reset SHALL force state=IDLE, rot=0, enc_instr=32'h0, enc_err=0, hence req_ready=1, enc_valid=0, on the next edge.
REQ-028 Reset mid-ROT or mid-OUT SHALL discard the pending request with no output handshake.

Structure
REQ-029 A shared package SHALL hold the kind codes, DP cmd codes (AND=0000, SUB=0010, ADD=0100, CMP=1010, ORR=1100, MOV=1101), state encoding and ERR_INSTR default.
REQ-030 Rotation test SHALL be a combinational sub-module imm_rot_check (imm32, rot -> match, imm8).

Verification
REQ-031 DP ADD cond=E, Rn=2, Rd=1, imm 0xFF -> enc_instr=0xE28210FF, err=0, enc_valid 2 cycles after accept.
REQ-032 DP MOV cmd=1101, Rd=0, imm 0xFF000000 -> 0xE3A004FF, err=0, enc_valid 6 cycles after accept.
REQ-033 DP imm 0x00000101 -> enc_instr=0xE1A00000, err=1, enc_valid 17 cycles after accept.
REQ-034 MEM load Rn=4, Rd=3, imm32=-8 -> 0xE5143008; BR link=1, imm32=0x100 -> 0xEB000040; BR imm32=0x102 -> err=1.
REQ-035 MUL Rd=1, Rm=2, Rs=3 -> 0xE0010392, enc_ready held low 5 cycles -> output stable, req_ready=0 throughout.
REQ-036 Reset asserted at rot=3 of a search -> next cycle req_ready=1, enc_valid=0, no output ever produced for that request.
